// File: rtl/score_collector_if.sv
// Score stream in, assembled frame out, plus frame error flags.
// The collector side takes the slave modport.
interface score_collector_if #(
  parameter int DATA_WIDTH  = 320,
  parameter int NUM_VALUES  = 10,
  parameter int VALUE_WIDTH = DATA_WIDTH / NUM_VALUES,
  parameter int CNT_W       = $clog2(NUM_VALUES + 1)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [VALUE_WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [CNT_W-1:0]       out_count;
  logic                   err_short;
  logic                   err_nolast;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, err_short, err_nolast
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, err_short, err_nolast
  );
endinterface

// File: rtl/score_collector.sv
// Packs a stream of per-class scores into one frame; out_valid one cycle after the closing beat.
// Backpressure: in_ready drops while a frame is held; one idle in_ready cycle per frame.
module score_collector #(
  parameter int DATA_WIDTH  = 320,
  parameter int NUM_VALUES  = 10,
  parameter int VALUE_WIDTH = DATA_WIDTH / NUM_VALUES,
  localparam int CNT_W      = $clog2(NUM_VALUES + 1)
) (
  input logic               clk,
  input logic               rst_n,
  score_collector_if.slave  bus
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VALUES - 1);

  state_t                 state_q, state_d;
  logic                   armed_q;
  logic [CNT_W-1:0]       idx_q;
  logic [VALUE_WIDTH-1:0] slot_q [NUM_VALUES];
  logic                   err_short_q;
  logic                   err_nolast_q;

  logic                   in_ready_w;
  logic                   out_valid_w;
  logic                   accept;
  logic                   final_beat;
  logic                   release_frame;
  logic [DATA_WIDTH-1:0]  data_pack;

  // armed_q keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state_q)
      FILL: begin
        in_ready_w = armed_q && rst_n;
        if (final_beat) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign accept        = bus.in_valid && in_ready_w;
  assign final_beat    = accept && (bus.in_last || (idx_q == LAST_IDX));
  assign release_frame = out_valid_w && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (release_frame) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= idx_q + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_VALUES; i++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q[i] <= '0;
      end else if (release_frame) begin
        slot_q[i] <= '0;
      end else if (accept && (idx_q == CNT_W'(i))) begin
        slot_q[i] <= bus.in_data;
      end
    end
  end

  // Error flags are decided by the beat that closes the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short_q  <= 1'b0;
      err_nolast_q <= 1'b0;
    end else if (release_frame) begin
      err_short_q  <= 1'b0;
      err_nolast_q <= 1'b0;
    end else if (final_beat) begin
      err_short_q  <= bus.in_last && (idx_q != LAST_IDX);
      err_nolast_q <= !bus.in_last && (idx_q == LAST_IDX);
    end
  end

  always_comb begin
    data_pack = '0;
    for (int i = 0; i < NUM_VALUES; i++) begin
      data_pack[i*VALUE_WIDTH +: VALUE_WIDTH] = slot_q[i];
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_w;
  assign bus.out_data   = data_pack;
  assign bus.out_count  = idx_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_nolast = err_nolast_q;

endmodule

// File: tb/tb_score_collector.sv
// Randomised and directed bench for score_collector against a frame-level reference model.
module tb_score_collector;
  localparam int DW = 320;
  localparam int N  = 10;
  localparam int VW = 32;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] count;
    logic          es;
    logic          en;
  } frame_t;

  typedef struct {
    logic [VW-1:0] d;
    bit            l;
  } beat_t;

  logic clk;
  logic rst_n;

  score_collector_if #(.DATA_WIDTH(DW), .NUM_VALUES(N), .VALUE_WIDTH(VW)) ifc ();

  score_collector #(.DATA_WIDTH(DW), .NUM_VALUES(N), .VALUE_WIDTH(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     stalls   = 0;
  beat_t  beats_q[$];
  frame_t exp_q[$];
  frame_t got_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Captures every frame handed downstream
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      got_q.push_back({ifc.out_data, ifc.out_count, ifc.err_short, ifc.err_nolast});
    end
  end

  // Reference: split the beat list into frames by in_last or N beats, zero-fill the rest
  function automatic void build_expected();
    frame_t cur;
    int     n;
    exp_q.delete();
    cur = '0;
    n   = 0;
    foreach (beats_q[k]) begin
      cur.data[n*VW +: VW] = beats_q[k].d;
      n++;
      if (beats_q[k].l || n == N) begin
        cur.count = CW'(n);
        cur.es    = beats_q[k].l && (n < N);
        cur.en    = !beats_q[k].l && (n == N);
        exp_q.push_back(cur);
        cur = '0;
        n   = 0;
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got_q.delete();
  endtask

  task automatic drive_range(input int from, input int to, input int gap_pct, output bit ok);
    int tmo;
    ok = 1'b1;
    for (int i = from; i < to; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      ifc.in_valid = 1'b1;
      ifc.in_data  = beats_q[i].d;
      ifc.in_last  = beats_q[i].l;
      tmo = 0;
      forever begin
        @(negedge clk);
        if (ifc.in_ready) break;
        stalls++;
        tmo++;
        if (tmo > 200) begin
          ok = 1'b0;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int cnt = 0;
    while (got_q.size() < n && cnt < 500) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    #3;
    n_checks++;
    if ({ifc.in_ready, ifc.out_valid, ifc.err_short, ifc.err_nolast} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b need 0000", {ifc.in_ready, ifc.out_valid, ifc.err_short, ifc.err_nolast});
      n_fail++;
    end
    n_checks++;
    if (ifc.out_count !== '0 || ifc.out_data !== '0) begin
      $display("FAIL reset_data: count %0d data %h need zero", ifc.out_count, ifc.out_data);
      n_fail++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ifc.in_ready !== 1'b0) begin
      $display("FAIL reset_early_ready: got %b need 0", ifc.in_ready);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (ifc.in_ready !== 1'b1) begin
      $display("FAIL reset_ready_after_edge: got %b need 1", ifc.in_ready);
      n_fail++;
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    do_reset();
    beats_q.delete();
    for (int i = 0; i < N; i++) beats_q.push_back('{d: VW'(10 * (i + 1)), l: (i == N - 1)});
    build_expected();
    drive_range(0, N, 0, ok);
    n_checks++;
    if (ifc.out_valid !== 1'b1 || !ok) begin
      $display("FAIL full_latency: out_valid %b drive_ok %0d need 1 1", ifc.out_valid, ok);
      n_fail++;
    end
    ifc.out_ready = 1'b1;
    wait_frames(1, ok);
    ifc.out_ready = 1'b0;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL full_count_frames: got %0d need %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL full_frame %0d: got %h need %h", i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit     ok;
    frame_t now;
    do_reset();
    beats_q.delete();
    for (int i = 0; i < N; i++) beats_q.push_back('{d: $urandom, l: (i == N - 1)});
    build_expected();
    drive_range(0, N, 0, ok);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'hDEAD_BEEF;
    ifc.in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      now = {ifc.out_data, ifc.out_count, ifc.err_short, ifc.err_nolast};
      n_checks++;
      if (now !== exp_q[0] || ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin
        $display("FAIL bp_hold cyc %0d: got %h rdy %b vld %b need %h 0 1", c, now, ifc.in_ready, ifc.out_valid, exp_q[0]);
        n_fail++;
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    n_checks++;
    if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL bp_release: frames %0d need 1, first %h need %h", got_q.size(), got_q[0], exp_q[0]);
      n_fail++;
    end
    n_checks++;
    if ({ifc.out_valid, ifc.in_ready, ifc.out_count, ifc.err_short, ifc.err_nolast} !== {2'b01, CW'(0), 2'b00}
        || ifc.out_data !== '0) begin
      $display("FAIL bp_cleared: vld %b rdy %b count %0d data %h need 0 1 0 zero",
               ifc.out_valid, ifc.in_ready, ifc.out_count, ifc.out_data);
      n_fail++;
    end
  endtask

  task automatic test_short_frame();
    bit ok;
    do_reset();
    beats_q.delete();
    beats_q.push_back('{d: 7, l: 0});
    beats_q.push_back('{d: 8, l: 0});
    beats_q.push_back('{d: 9, l: 1});
    build_expected();
    ifc.out_ready = 1'b1;
    drive_range(0, beats_q.size(), 0, ok);
    wait_frames(1, ok);
    n_checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      $display("FAIL short_frames: got %0d need %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL short_frame %0d: got %h need %h", i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_missing_last();
    bit ok;
    do_reset();
    beats_q.delete();
    for (int i = 1; i <= 12; i++) beats_q.push_back('{d: VW'(i), l: 0});
    beats_q.push_back('{d: 13, l: 1});
    build_expected();
    ifc.out_ready = 1'b1;
    drive_range(0, beats_q.size(), 0, ok);
    wait_frames(exp_q.size(), ok);
    n_checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      $display("FAIL nolast_frames: got %0d need %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL nolast_frame %0d: got %h need %h", i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    beats_q.delete();
    for (int i = 1; i <= 4; i++) beats_q.push_back('{d: VW'(100 + i), l: 0});
    drive_range(0, 4, 0, ok);
    do_reset();
    n_checks++;
    if (ifc.out_valid !== 1'b0 || ifc.out_data !== '0 || ifc.out_count !== '0) begin
      $display("FAIL midreset_clear: vld %b count %0d data %h need 0 0 zero", ifc.out_valid, ifc.out_count, ifc.out_data);
      n_fail++;
    end
    beats_q.delete();
    for (int i = 0; i < N; i++) beats_q.push_back('{d: VW'(5 + i), l: (i == N - 1)});
    build_expected();
    ifc.out_ready = 1'b1;
    drive_range(0, N, 0, ok);
    wait_frames(1, ok);
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 1) begin
      $display("FAIL midreset_frames: got %0d need 1", got_q.size());
      n_fail++;
    end else begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin
        $display("FAIL midreset_frame: got %h need %h", got_q[0], exp_q[0]);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    beats_q.delete();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        beats_q.push_back('{d: (i == f) ? 32'hFFFF_FFFF : $urandom, l: (i == N - 1)});
      end
    end
    build_expected();
    ifc.out_ready = 1'b1;
    stalls = 0;
    drive_range(0, beats_q.size(), 0, ok);
    n_checks++;
    if (stalls !== 2 || !ok) begin
      $display("FAIL b2b_bubbles: got %0d idle cycles need 2", stalls);
      n_fail++;
    end
    wait_frames(exp_q.size(), ok);
    n_checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      $display("FAIL b2b_frames: got %0d need %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL b2b_frame %0d: got %h need %h", i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit done;
    do_reset();
    beats_q.delete();
    for (int i = 0; i < 60; i++) beats_q.push_back('{d: $urandom, l: ($urandom_range(0, 5) == 0) || (i == 59)});
    build_expected();
    done = 1'b0;
    fork
      begin
        drive_range(0, beats_q.size(), 30, ok);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ifc.out_ready = ($urandom_range(0, 1) == 1);
        end
        ifc.out_ready = 1'b1;
      end
    join
    wait_frames(exp_q.size(), ok);
    n_checks++;
    if (!ok || got_q.size() !== exp_q.size()) begin
      $display("FAIL rand_frames: got %0d need %0d", got_q.size(), exp_q.size());
      n_fail++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL rand_frame %0d: got %h need %h", i, got_q[i], exp_q[i]);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_short_frame();
    test_missing_last();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/score_collector.md
SCORE_COLLECTOR -- requirements
Module: score_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 320, SHALL set the packed score bus width.
REQ-002 Parameter NUM_VALUES, default 10, SHALL set the number of class scores per frame.
REQ-003 Parameter VALUE_WIDTH, default DATA_WIDTH/NUM_VALUES (32), SHALL set the width of one unsigned score.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mark in_data/in_last valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a beat this cycle.
REQ-008 in_data  input  VALUE_WIDTH  SHALL carry one unsigned class score, class 0 first.
REQ-009 in_last  input  1  SHALL mark the final score of a frame.
REQ-010 out_valid  output  1  SHALL indicate out_data holds a complete frame.
REQ-011 out_ready  input  1  SHALL indicate the downstream argmax stage consumes the frame.
REQ-012 out_data  output  DATA_WIDTH  SHALL hold score i at bits [i*VALUE_WIDTH +: VALUE_WIDTH].
REQ-013 out_count  output  $clog2(NUM_VALUES+1)  SHALL give the number of scores received in the held frame.
REQ-014 err_short  output  1  SHALL flag a frame ended by in_last before NUM_VALUES beats.
REQ-015 err_nolast  output  1  SHALL flag a frame whose NUM_VALUES-th beat lacked in_last.

Function
REQ-016 FSM SHALL have two states: FILL (accepting) and HOLD (presenting).
REQ-017 Beat accepted iff in_valid && in_ready; in_ready SHALL equal (state==FILL) && rst_n.
REQ-018 Accepted beat SHALL be written to slot idx, then idx increments; idx starts at 0 each frame.
REQ-019 FILL->HOLD SHALL occur on the edge accepting a beat with in_last=1 or with idx==NUM_VALUES-1, whichever first.
REQ-020 Latency: out_valid SHALL rise the cycle after the final beat is accepted; no combinational in->out path.
REQ-021 In HOLD, out_valid=1, in_ready=0, and out_data/out_count/err flags SHALL remain stable until handshake.
REQ-022 HOLD->FILL SHALL occur on the edge where out_valid && out_ready; that edge clears all slots to zero, idx to 0, out_count to 0, both err flags to 0.
REQ-023 First beat of the next frame SHALL be acceptable in the cycle immediately after the HOLD->FILL edge (one bubble per frame).
REQ-024 Short frame (in_last at idx<NUM_VALUES-1): unfilled slots SHALL read zero; err_short=1 in HOLD; out_count=beats received.
REQ-025 Beat NUM_VALUES-1 accepted with in_last=0: frame SHALL close anyway, err_nolast=1; following beats belong to the next frame.
REQ-026 Beat NUM_VALUES-1 accepted with in_last=1: err_short=0, err_nolast=0, out_count=NUM_VALUES.
REQ-027 out_ready while in FILL SHALL be ignored; in_valid while in HOLD SHALL not alter state.
REQ-028 Scores SHALL be stored verbatim, unsigned, no saturation or truncation.

Reset
REQ-029 rst_n low SHALL immediately force state=FILL, idx=0, all slots=0, out_valid=0, out_count=0, err_short=0, err_nolast=0, in_ready=0.
REQ-030 Reset asserted mid-frame or in HOLD SHALL discard the partial/held frame; no out_valid follows until a new complete frame.
REQ-031 in_ready SHALL assert no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-032 Full frame: scores 10,20,...,100 back-to-back, in_last on 10th -> out_valid next cycle, slot i = 10*(i+1), out_count=10, errs 0.
REQ-033 Backpressure: full frame, out_ready low 5 cycles -> out_data stable, in_ready=0 throughout, in_valid beats not accepted; frame released on out_ready.
REQ-034 Short frame: 7,8,9 with in_last on 9 -> slots 0..2 = 7,8,9, slots 3..9 = 0, out_count=3, err_short=1.
REQ-035 Missing last: 12 beats 1..12, in_last never -> frame 1..10 with err_nolast=1; after handshake, 11,12 occupy slots 0,1 of next frame.
REQ-036 Reset mid-frame: reset after 4 beats, then full frame 5..14 -> only one out_valid, slots 5..14, no residue from earlier beats.
REQ-037 Back-to-back frames with out_ready tied high -> exactly one idle in_ready cycle between frames, all data correct, 0xFFFFFFFF score passes unchanged.
